// File: rtl/multiply_add_seq.sv
// Sequential radix-2 shift-add multiply-accumulate: product = multiplicand*multiplier + addend.
// Latency: ready low for exactly WIDTH+1 cycles after an accepted start; product and ready update together.
// Backpressure: start is honoured only while ready=1; requests while busy are dropped, not queued.
//
// Ports:
//   i_clk            rising-edge clock
//   i_reset          asynchronous active-high reset; aborts any operation in flight
//   i_start          request, accepted on an edge where o_ready=1
//   i_sign           1 = operands are two's complement, 0 = unsigned
//   i_multiplicand   operand A, sampled on the accepting edge only
//   i_multiplier     operand B, sampled on the accepting edge only
//   i_addend         operand C, sign- or zero-extended to 2*WIDTH by i_sign
//   o_product        2*WIDTH result register, holds the last completed result
//   o_ready          1 = idle and o_product valid, 0 = busy
//
// The unit is the inverse of the divider: feeding it quotient, divisor and
// remainder regenerates the dividend. The multiply runs on magnitudes and the
// result sign is applied once at the end, matching the divider's convention.

module multiply_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_sign,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  input  logic [WIDTH-1:0]   i_addend,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_ready
);

  // Counter only needs to reach WIDTH-1; the +1 keeps the width legal for tiny WIDTH.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [2*WIDTH-1:0] r_acc;       // partial product, upper half receives |A|
  logic [WIDTH-1:0]   r_amag;      // |A|
  logic [WIDTH-1:0]   r_bmag;      // |B|, consumed LSB first
  logic [2*WIDTH-1:0] r_c_ext;     // addend already extended to result width
  logic               r_neg;       // result of the multiply is negative
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic               r_ready;

  // ---------------------------------------------------------------------------
  // Operand conditioning on the accepting edge
  // ---------------------------------------------------------------------------
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_c_ext;
  logic               w_neg;

  always_comb begin
    w_a_neg = i_sign & i_multiplicand[WIDTH-1];
    w_b_neg = i_sign & i_multiplier[WIDTH-1];
    // Negating the most negative value wraps back to itself, which read as
    // unsigned is exactly its magnitude 2^(WIDTH-1).
    w_a_mag = w_a_neg ? -i_multiplicand : i_multiplicand;
    w_b_mag = w_b_neg ? -i_multiplier   : i_multiplier;
    w_neg   = w_a_neg ^ w_b_neg;
    if (i_sign) begin
      w_c_ext = {{WIDTH{i_addend[WIDTH-1]}}, i_addend};
    end else begin
      w_c_ext = {{WIDTH{1'b0}}, i_addend};
    end
  end

  // ---------------------------------------------------------------------------
  // One shift-add step
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     w_hi_sum;    // upper half plus |A|, carry bit kept
  logic [WIDTH:0]     w_hi_sel;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_bmag_next;

  always_comb begin
    w_hi_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_amag};
    w_hi_sel = r_bmag[0] ? w_hi_sum : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    // Right shift of {carry, acc, B}: the carry re-enters at the top of acc and
    // the acc LSB drops into the vacated multiplier MSB (never inspected again).
    w_acc_next  = {w_hi_sel, r_acc[WIDTH-1:1]};
    w_bmag_next = {r_acc[0], r_bmag[WIDTH-1:1]};
  end

  // ---------------------------------------------------------------------------
  // Final sign application and accumulate
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_acc_signed;
  logic [2*WIDTH-1:0] w_result;

  always_comb begin
    w_acc_signed = r_neg ? -r_acc : r_acc;
    w_result     = w_acc_signed + r_c_ext;
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_amag    <= '0;
      r_bmag    <= '0;
      r_c_ext   <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
      r_ready   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_amag  <= w_a_mag;
            r_bmag  <= w_b_mag;
            r_c_ext <= w_c_ext;
            r_neg   <= w_neg;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Always WIDTH steps; zero operands take the same time on purpose so
          // latency is fixed for the datapath scheduler.
          r_acc  <= w_acc_next;
          r_bmag <= w_bmag_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_FINISH;
          end
        end

        ST_FINISH: begin
          r_product <= w_result;
          r_ready   <= 1'b1;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_product = r_product;
  assign o_ready   = r_ready;

endmodule

// File: tb/tb_multiply_add_seq.sv
// Directed-vector bench for multiply_add_seq with hand-computed results.
// Latency: checks ready is low for exactly WIDTH+1 cycles per operation.
// Backpressure: checks that starts while busy are dropped and held-start chains back-to-back.

module tb_multiply_add_seq;

  localparam int W       = 32;
  localparam int LAT     = W + 1;
  localparam int BOUND   = 200;

  logic          clk;
  logic          reset;
  logic          start;
  logic          sign;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  c;
  logic [2*W-1:0] product;
  logic          ready;

  int n_vec;
  int n_err;

  multiply_add_seq #(.WIDTH(W)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_sign         (sign),
    .i_multiplicand (a),
    .i_multiplier   (b),
    .i_addend       (c),
    .o_product      (product),
    .o_ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (sampling 1 time unit after each edge) until ready rises; returns the
  // number of edges seen, or BOUND on timeout.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!ready && cyc < BOUND) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic s, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [W-1:0] vc,
                       input logic [63:0] exp);
    int cyc;
    @(negedge clk);
    check({tag, "_idle"}, 64'(ready), 64'd1);
    sign = s; a = va; b = vb; c = vc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, 64'(ready), 64'd0);
    wait_ready(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(LAT));
    check({tag, "_prod"}, product, exp);
  endtask

  initial begin
    int cyc;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    sign  = 1'b0;
    a = '0; b = '0; c = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_prod", product, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic signed products
    do_op("t2a", 1'b1, 32'd10, 32'd2, 32'd0, 64'd20);
    do_op("t2b", 1'b1, 32'd3, 32'd3, 32'd1, 64'd10);

    // Reset in the middle of RUN: async clear, old result discarded
    @(negedge clk);
    sign = 1'b1; a = 32'd100; b = 32'd100; c = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("abort_busy", 64'(ready), 64'd0);
    check("abort_oldprod", product, 64'd10);
    reset = 1'b1;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_prod", product, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_noresult", product, 64'd0);
    do_op("t1_after", 1'b1, 32'd6, 32'd7, 32'd5, 64'd47);

    // Negative operands and the divider round trip 10 / -4 = -2 rem 2
    do_op("t3a", 1'b1, 32'hFFFF_FFFB, 32'd2, 32'd0, 64'hFFFF_FFFF_FFFF_FFF6);
    do_op("t3b", 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'd2, 64'd10);
    do_op("t3c", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEA);

    // Extremes
    do_op("t4u", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
    do_op("t4s", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0, 64'h4000_0000_0000_0000);
    do_op("t4z", 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd9, 64'd9);

    // Starts while busy are ignored
    @(negedge clk);
    sign = 1'b0; a = 32'd9; b = 32'd9; c = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!ready && cyc < BOUND) begin
      if (cyc == 5 || cyc == 20) begin
        start = 1'b1; a = 32'd1; b = 32'd1; c = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc == 10 || cyc == 25) check("t5_oldprod", product, 64'd9);
    end
    start = 1'b0;
    check("t5_lat", 64'(cyc), 64'(LAT));
    check("t5_prod", product, 64'd81);
    repeat (3) begin @(posedge clk); #1; end
    check("t5_stillidle", 64'(ready), 64'd1);
    check("t5_stillprod", product, 64'd81);

    // Start held high: back-to-back operations, one idle cycle between them
    @(negedge clk);
    sign = 1'b0; a = 32'd7; b = 32'd6; c = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    check("t6_busy0", 64'(ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      wait_ready(cyc);
      check("t6_lat", 64'(cyc), 64'(LAT));
      check("t6_prod", product, 64'd42);
      @(posedge clk); #1;
      check("t6_rebusy", 64'(ready), 64'd0);
    end
    start = 1'b0;
    wait_ready(cyc);
    check("t6_last_lat", 64'(cyc), 64'(LAT));
    check("t6_last_prod", product, 64'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
